// File: rtl/instr_fetch.sv
// Instruction-fetch stage: fetch PC, ROM addressing, instruction register, valid/ready out.
// Optional misaligned-redirect trap enabled by defining IFETCH_ALIGN_CHECK_EN.
module instr_fetch #(
  parameter int          WIDTH      = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic [WIDTH-1:0]      instr,
  output logic [31:0]           instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic [31:0]           fetch_pc,
  output logic                  fetch_err
);

`ifdef IFETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {FETCH, HOLD, ERR} state_t;
`else
  typedef enum logic [1:0] {FETCH, HOLD} state_t;
`endif

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0]   instr_q, instr_d;
  logic [31:0]        instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;
  logic               load;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic               err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    load       = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    err_d      = err_q;
`endif
    unique case (state_q)
      FETCH, HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          state_d = FETCH;
`ifdef IFETCH_ALIGN_CHECK_EN
          fetch_pc_d = redirect_pc;
          if (redirect_pc[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = ERR;
          end
`else
          fetch_pc_d = redirect_pc & ~32'h3;
`endif
        end else if (state_q == FETCH || instr_ready) begin
          load = 1'b1;
        end
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      ERR: ;
`endif
      default: state_d = FETCH;
    endcase
    // Accepting the held word and loading the next share one edge: no bubble.
    if (load) begin
      instr_d    = rom_data;
      instr_pc_d = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
      valid_d    = 1'b1;
      state_d    = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
`ifdef IFETCH_ALIGN_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign rom_addr    = fetch_pc_q[ADDR_WIDTH+1:2];
  assign fetch_pc    = fetch_pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign fetch_err   = err_q;
`else
  assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed + randomized bench for instr_fetch against a behavioural fetch model.
// Expectations for misaligned redirects follow IFETCH_ALIGN_CHECK_EN.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;
  logic        fetch_err;

  logic [31:0] rom [1024];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_fpc, m_instr, m_ipc;
  logic        m_valid, m_err, m_trap;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  instr_fetch #(.WIDTH(32), .ADDR_WIDTH(10), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_pc(fetch_pc), .fetch_err(fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: one clock of fetch-stage behaviour from the current inputs.
  task automatic model_step();
    bit align_chk;
`ifdef IFETCH_ALIGN_CHECK_EN
    align_chk = 1'b1;
`else
    align_chk = 1'b0;
`endif
    if (rst) begin
      m_fpc = 0; m_instr = 0; m_ipc = 0;
      m_valid = 0; m_err = 0; m_trap = 0;
    end else if (m_trap) begin
    end else if (redirect) begin
      m_valid = 0;
      if (align_chk && redirect_pc % 4 != 0) begin
        m_err = 1; m_trap = 1; m_fpc = redirect_pc;
      end else begin
        m_fpc = redirect_pc - redirect_pc % 4;
      end
    end else if (!m_valid || instr_ready) begin
      m_instr = rom[(m_fpc / 4) % 1024];
      m_ipc   = m_fpc;
      m_fpc   = m_fpc + 4;
      m_valid = 1;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    chk("fetch_pc", fetch_pc, m_fpc);
    chk("rom_addr", {22'd0, rom_addr}, {22'd0, m_fpc[11:2]});
    chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0] = 32'h2008_0005;
    m_fpc = 32'hx; m_instr = 32'hx; m_ipc = 32'hx;
    m_valid = 0; m_err = 0; m_trap = 0;
    rst = 1; instr_ready = 0; redirect = 0; redirect_pc = 0;

    // Reset
    step();
    step();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fpc", fetch_pc, 32'h0);
    rst = 0;
    step();
    chk("first_instr", instr, 32'h2008_0005);
    chk("first_fpc", fetch_pc, 32'h4);

    // Accept A, then backpressure holding B
    instr_ready = 1;
    step();
    chk("b_pc", instr_pc, 32'h4);
    instr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_instr", instr, rom[1]);
      chk("bp_fpc", fetch_pc, 32'h8);
    end
    instr_ready = 1;
    step();
    step();
    chk("d_pc", instr_pc, 32'hC);

    // Streaming from 0: A,B,C,D on consecutive cycles
    redirect = 1; redirect_pc = 32'h0;
    step();
    redirect = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_instr", instr, rom[i]);
      chk("stream_pc", instr_pc, 32'(4 * i));
    end

    // Redirect while a valid instruction is being accepted
    redirect = 1; redirect_pc = 32'h40;
    step();
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_addr", {22'd0, rom_addr}, 32'h010);
    redirect = 0;
    step();
    chk("redir_instr", instr, rom[16]);
    chk("redir_pc", instr_pc, 32'h40);

    // ROM index wrap
    redirect = 1; redirect_pc = 32'h0000_0FFC;
    step();
    chk("wrap_addr0", {22'd0, rom_addr}, 32'h3FF);
    redirect = 0;
    step();
    chk("wrap_pc0", instr_pc, 32'hFFC);
    chk("wrap_addr1", {22'd0, rom_addr}, 32'h000);
    step();
    chk("wrap_pc1", instr_pc, 32'h1000);

    // Misaligned redirect
    redirect = 1; redirect_pc = 32'h42;
    step();
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("align_err", {31'd0, fetch_err}, 32'd1);
    chk("align_fpc", fetch_pc, 32'h42);
    redirect_pc = 32'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("trap_valid", {31'd0, instr_valid}, 32'd0);
    end
    redirect = 0;
    rst = 1;
    step();
    rst = 0;
    chk("trap_clear", {31'd0, fetch_err}, 32'd0);
`else
    chk("align_err", {31'd0, fetch_err}, 32'd0);
    chk("align_fpc", fetch_pc, 32'h40);
`endif
    redirect = 0;

    // Randomized traffic, including pc wrap near 2^32 and mid-run resets
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      instr_ready = $urandom_range(0, 1) == 1;
      redirect = ($urandom_range(0, 7) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 3) == 0) redirect_pc[31:4] = '1;
      if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
